// File: rtl/layer_sequencer_pkg.sv
// rtl/layer_sequencer_pkg.sv - shared constants for the layer sequencer
package layer_sequencer_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam int ROM_ADDR_W  = 11;
    localparam int LANES       = 128;
    localparam int BIT_DEFAULT = 16;

endpackage

// File: rtl/layer_sequencer_lane_mux.sv
// rtl/layer_sequencer_lane_mux.sv - N:1 one-hot-or-zero AND-OR lane mux
module lane_mux #(
    parameter int N = 3,
    parameter int W = 11
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] lanes,
    output logic [W-1:0]   out
);

    // AND-OR select: unselected lanes are masked so undriven inputs cannot leak through
    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++) begin
            out = out | ({W{sel[i]}} & lanes[i*W +: W]);
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - in-order scheduler for the layer engines with shared bus muxing
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int IDX_W      = 2,
    parameter int BIT        = BIT_DEFAULT,
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 65535
) (
    input  logic                          clk,
    input  logic                          iRst_n,
    input  logic                          iStart,
    input  logic                          iAbort,
    input  logic [NUM_LAYERS-1:0]         iLayerDone,
    input  logic [NUM_LAYERS-1:0]         iLayerOvf,
    input  logic [NUM_LAYERS*ADDR_W-1:0]  iRomAddr,
    input  logic [NUM_LAYERS*LANES*BIT-1:0] iOpr1,
    input  logic [NUM_LAYERS*LANES*BIT-1:0] iOpr2,
    output logic [NUM_LAYERS-1:0]         oLayerEna,
    output logic [NUM_LAYERS-1:0]         oLayerRst_n,
    output logic [ADDR_W-1:0]             oRomAddr,
    output logic [LANES*BIT-1:0]          oOpr1,
    output logic [LANES*BIT-1:0]          oOpr2,
    output logic [IDX_W-1:0]              oLayerIdx,
    output logic                          oBusy,
    output logic                          oDone,
    output logic                          oOverflow,
    output logic                          oTimeout
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [2:0]            state, state_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic [RC_W-1:0]       rcnt;
    logic [WD_W-1:0]       wdog;
    logic [NUM_LAYERS-1:0] ena, rst_n;
    logic                  busy, done_flag, ovf_flag, to_flag;
    logic                  launch, sel_done, sel_ovf;

    function automatic logic [NUM_LAYERS-1:0] dec(input logic [IDX_W-1:0] i);
        logic [NUM_LAYERS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            v[k] = (i == IDX_W'(k));
        end
        return v;
    endfunction

    // Only the enabled engine's status may matter, and only while it is running
    always_comb begin
        sel_done = (state == S_RUN) && |(iLayerDone & ena);
        sel_ovf  = |(iLayerOvf & ena);
    end

    // Next state and layer index; abort overrides everything, done beats the watchdog
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        launch   = 1'b0;
        if (iAbort) begin
            state_nx = S_IDLE;
            idx_nx   = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (iStart) begin
                        state_nx = S_LOAD;
                        idx_nx   = '0;
                        launch   = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (rcnt == RC_W'(RST_CYCLES - 1)) state_nx = S_RUN;
                end
                S_RUN: begin
                    if (sel_done) begin
                        state_nx = (idx == IDX_W'(NUM_LAYERS - 1)) ? S_DONE : S_GAP;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        state_nx = S_ERR;
                    end
                end
                S_GAP: begin
                    state_nx = S_LOAD;
                    idx_nx   = idx + 1'b1;
                end
                default: begin
                    state_nx = S_IDLE;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    // Register state, counters and every control/status output from the next-state view
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            rcnt      <= '0;
            wdog      <= '0;
            ena       <= '0;
            rst_n     <= '1;
            busy      <= 1'b0;
            done_flag <= 1'b0;
            ovf_flag  <= 1'b0;
            to_flag   <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            rcnt  <= (state == S_LOAD && state_nx == S_LOAD) ? rcnt + 1'b1 : '0;
            wdog  <= (state == S_RUN && state_nx == S_RUN) ? wdog + 1'b1 : '0;
            ena   <= (state_nx == S_LOAD || state_nx == S_RUN) ? dec(idx_nx) : '0;
            rst_n <= (state_nx == S_LOAD) ? ~dec(idx_nx) : '1;
            busy  <= (state_nx == S_LOAD) || (state_nx == S_RUN) || (state_nx == S_GAP);
            if (launch) begin
                done_flag <= 1'b0;
                ovf_flag  <= 1'b0;
                to_flag   <= 1'b0;
            end else begin
                if (!iAbort && sel_done) ovf_flag <= ovf_flag | sel_ovf;
                if (state_nx == S_DONE) done_flag <= 1'b1;
                if (state_nx == S_ERR)  to_flag   <= 1'b1;
            end
        end
    end

    lane_mux #(.N(NUM_LAYERS), .W(ADDR_W)) u_rom_mux (
        .sel   (ena),
        .lanes (iRomAddr),
        .out   (oRomAddr)
    );

    lane_mux #(.N(NUM_LAYERS), .W(LANES*BIT)) u_opr1_mux (
        .sel   (ena),
        .lanes (iOpr1),
        .out   (oOpr1)
    );

    lane_mux #(.N(NUM_LAYERS), .W(LANES*BIT)) u_opr2_mux (
        .sel   (ena),
        .lanes (iOpr2),
        .out   (oOpr2)
    );

    assign oLayerEna   = ena;
    assign oLayerRst_n = rst_n;
    assign oLayerIdx   = idx;
    assign oBusy       = busy;
    assign oDone       = done_flag;
    assign oOverflow   = ovf_flag;
    assign oTimeout    = to_flag;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - self-checking bench for layer_sequencer
module tb_layer_sequencer;

    localparam int TO = 128;
    localparam int WB = 128 * 16;

    logic               clk = 1'b0;
    logic               iRst_n, iStart, iAbort;
    logic [2:0]         iLayerDone, iLayerOvf;
    logic [3*11-1:0]    iRomAddr;
    logic [3*WB-1:0]    iOpr1, iOpr2;
    logic [2:0]         oLayerEna, oLayerRst_n;
    logic [10:0]        oRomAddr;
    logic [WB-1:0]      oOpr1, oOpr2;
    logic [1:0]         oLayerIdx;
    logic               oBusy, oDone, oOverflow, oTimeout;

    layer_sequencer #(
        .NUM_LAYERS(3), .IDX_W(2), .BIT(16), .ADDR_W(11), .RST_CYCLES(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .iRst_n(iRst_n), .iStart(iStart), .iAbort(iAbort),
        .iLayerDone(iLayerDone), .iLayerOvf(iLayerOvf), .iRomAddr(iRomAddr),
        .iOpr1(iOpr1), .iOpr2(iOpr2), .oLayerEna(oLayerEna), .oLayerRst_n(oLayerRst_n),
        .oRomAddr(oRomAddr), .oOpr1(oOpr1), .oOpr2(oOpr2), .oLayerIdx(oLayerIdx),
        .oBusy(oBusy), .oDone(oDone), .oOverflow(oOverflow), .oTimeout(oTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ena;
        logic [2:0] rst;
        int         idx;
        bit         busy;
        bit         done;
        bit         ovf;
        bit         to;
    } rec_t;

    rec_t       exp_q[$];
    logic [2:0] hist[$];
    logic [2:0] last_ena = 3'b000;
    int         load0 = 0, run0 = 0;
    int         checks = 0, failures = 0;
    bit         m_done = 0, m_ovf = 0, m_to = 0;

    // engine models: done after dur[i] RUN cycles; spur drives done on every idle/loading engine
    int  dur[3] = '{1, 1, 1};
    int  ecnt[3] = '{0, 0, 0};
    bit  spur = 0;
    logic [10:0] rom_lane[3] = '{11'h011, 11'h222, 11'h333};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            ecnt[i] <= (oLayerEna[i] && oLayerRst_n[i]) ? ecnt[i] + 1 : 0;
    end

    always_comb begin
        iLayerDone = '0;
        for (int i = 0; i < 3; i++) begin
            if (oLayerEna[i] && oLayerRst_n[i]) iLayerDone[i] = (ecnt[i] == dur[i] - 1);
            else                                iLayerDone[i] = spur;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        int k;
        checks++;
        if (act !== exp) begin
            failures++;
            k = 0;
            for (int j = 127; j >= 0; j--)
                if (act[j*16 +: 16] !== exp[j*16 +: 16]) k = j;
            $display("FAIL %s at %0t lane %0d: got %h expected %h", name, $time, k, act[k*16 +: 16], exp[k*16 +: 16]);
        end
    endtask

    task automatic push_rec(inout int n, input int cut, input logic [2:0] e, input logic [2:0] r,
                            input int ix, input bit b);
        if (n < cut) exp_q.push_back('{e, r, ix, b, m_done, m_ovf, m_to});
        n++;
    endtask

    // Expected per-cycle trace of one inference: LOAD 2, RUN d, GAP 1 per layer, then DONE;
    // d > TO means the watchdog fires; records past 'cut' are replaced by IDLE (abort).
    task automatic plan(input int d0, input int d1, input int d2, input logic [2:0] ovm,
                        input int cut, input int tail);
        int d[3];
        int n;
        bit stop;
        d[0] = d0; d[1] = d1; d[2] = d2;
        n = 0; stop = 0;
        m_done = 0; m_ovf = 0; m_to = 0;
        for (int L = 0; L < 3 && !stop; L++) begin
            for (int c = 0; c < 2; c++) push_rec(n, cut, 3'(1 << L), ~3'(1 << L), L, 1);
            if (d[L] > TO) begin
                for (int c = 0; c < TO; c++) push_rec(n, cut, 3'(1 << L), 3'b111, L, 1);
                if (n < cut) m_to = 1;
                for (int c = 0; c < tail; c++) push_rec(n, cut, 3'b000, 3'b111, L, 0);
                stop = 1;
            end else begin
                for (int c = 0; c < d[L]; c++) push_rec(n, cut, 3'(1 << L), 3'b111, L, 1);
                if (n < cut) m_ovf = m_ovf | ovm[L];
                if (L < 2) push_rec(n, cut, 3'b000, 3'b111, L, 1);
                else begin
                    if (n < cut) m_done = 1;
                    for (int c = 0; c < tail; c++) push_rec(n, cut, 3'b000, 3'b111, L, 0);
                end
            end
        end
        if (cut < n)
            for (int c = 0; c < tail; c++) exp_q.push_back('{3'b000, 3'b111, 0, 0, m_done, m_ovf, m_to});
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic launch(input int d0, input int d1, input int d2, input logic [2:0] ovm,
                          input int hold);
        dur[0] = d0; dur[1] = d1; dur[2] = d2;
        iLayerOvf = ovm;
        @(negedge clk); #1;
        plan(d0, d1, d2, ovm, 1 << 30, 3);
        iStart = 1;
        repeat (hold) @(negedge clk);
        #1 iStart = 0;
    endtask

    // Per-cycle comparison against the trace, plus the one-hot invariant and ena history
    initial begin
        rec_t r;
        logic [WB-1:0] e1, e2;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("ena", 64'(oLayerEna), 64'(r.ena));
                chk("rst_n", 64'(oLayerRst_n), 64'(r.rst));
                chk("idx", 64'(oLayerIdx), 64'(r.idx));
                chk("busy", 64'(oBusy), 64'(r.busy));
                chk("done", 64'(oDone), 64'(r.done));
                chk("ovf", 64'(oOverflow), 64'(r.ovf));
                chk("timeout", 64'(oTimeout), 64'(r.to));
                chk("rom", 64'(oRomAddr), (r.ena != 0) ? 64'(rom_lane[r.idx]) : 64'd0);
                e1 = (r.ena != 0) ? iOpr1[r.idx*WB +: WB] : '0;
                e2 = (r.ena != 0) ? iOpr2[r.idx*WB +: WB] : '0;
                chk_wide("opr1", oOpr1, e1);
                chk_wide("opr2", oOpr2, e2);
            end
            checks++;
            if ($countones(oLayerEna) > 1) begin
                failures++;
                $display("FAIL onehot at %0t: ena %b has more than one bit set", $time, oLayerEna);
            end
            if (oLayerEna != last_ena) begin
                hist.push_back(oLayerEna);
                last_ena = oLayerEna;
            end
            if (oLayerEna == 3'b001) begin
                if (oLayerRst_n == 3'b111) run0++;
                else                       load0++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [2:0] ord[6];
        ord = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        iRst_n = 0; iStart = 0; iAbort = 0; iLayerOvf = 3'b000;
        iRomAddr = {rom_lane[2], rom_lane[1], rom_lane[0]};
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 128; j++) begin
                iOpr1[(i*128 + j)*16 +: 16] = 16'(16'h1000 + i*256 + j);
                iOpr2[(i*128 + j)*16 +: 16] = 16'(16'hF000 - i*4096 - j*3);
            end

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_ena", 64'(oLayerEna), 64'd0);
        chk("rst_rst_n", 64'(oLayerRst_n), 64'h7);
        chk("rst_idx", 64'(oLayerIdx), 64'd0);
        chk("rst_busy", 64'(oBusy), 64'd0);
        chk("rst_flags", {61'd0, oDone, oOverflow, oTimeout}, 64'd0);
        chk("rst_rom", 64'(oRomAddr), 64'd0);
        #1 iRst_n = 1;
        repeat (2) @(negedge clk);

        // clean run 100/50/20
        hist.delete(); load0 = 0; run0 = 0;
        launch(100, 50, 20, 3'b000, 1);
        wait_drain();
        chk("final_done", 64'(oDone), 64'd1);
        chk("final_ovf", 64'(oOverflow), 64'd0);
        chk("ena_order_len", 64'(hist.size()), 64'd6);
        for (int k = 0; k < 6; k++)
            chk("ena_order", (k < hist.size()) ? 64'(hist[k]) : 64'hFF, 64'(ord[k]));
        chk("load0_cycles", 64'(load0), 64'd2);
        chk("run0_cycles", 64'(run0), 64'd100);

        // layer 1 overflows; stray done/ovf from idle/loading engines; start held into LOAD
        spur = 1;
        launch(5, 6, 7, 3'b010, 2);
        wait_drain();
        chk("ovf_done", 64'(oDone), 64'd1);
        chk("ovf_sticky", 64'(oOverflow), 64'd1);
        spur = 0;

        // restart clears overflow on the LOAD edge; layer 2 done exactly at watchdog limit
        dur[0] = 3; dur[1] = 3; dur[2] = TO; iLayerOvf = 3'b000;
        @(negedge clk); #1;
        plan(3, 3, TO, 3'b000, 1 << 30, 3);
        iStart = 1;
        @(posedge clk); #1;
        chk("ovf_cleared", 64'(oOverflow), 64'd0);
        chk("load_ena", 64'(oLayerEna), 64'd1);
        @(negedge clk); #1 iStart = 0;
        wait_drain();
        chk("edge_done", 64'(oDone), 64'd1);
        chk("edge_timeout", 64'(oTimeout), 64'd0);

        // watchdog: layer 0 never finishes
        launch(1000, 1, 1, 3'b000, 1);
        wait_drain();
        chk("wd_timeout", 64'(oTimeout), 64'd1);
        chk("wd_ena", 64'(oLayerEna), 64'd0);
        chk("wd_done", 64'(oDone), 64'd0);

        // abort in layer 1 RUN, then start+abort together in IDLE
        dur[0] = 10; dur[1] = 20; dur[2] = 5; iLayerOvf = 3'b001;
        @(negedge clk); #1;
        plan(10, 20, 5, 3'b001, 20, 4);
        iStart = 1;
        @(negedge clk); #1 iStart = 0;
        repeat (19) @(negedge clk);
        #1 iAbort = 1; iStart = 1;
        @(negedge clk);
        @(negedge clk); #1 iAbort = 0; iStart = 0;
        wait_drain();
        chk("abort_idx", 64'(oLayerIdx), 64'd0);
        chk("abort_ena", 64'(oLayerEna), 64'd0);
        chk("abort_busy", 64'(oBusy), 64'd0);
        chk("abort_ovf_kept", 64'(oOverflow), 64'd1);

        // asynchronous reset mid-RUN, then a clean restart
        launch(100, 50, 20, 3'b000, 1);
        repeat (30) @(negedge clk);
        #3;
        exp_q.delete();
        iRst_n = 0;
        #1;
        chk("arst_ena", 64'(oLayerEna), 64'd0);
        chk("arst_rst_n", 64'(oLayerRst_n), 64'h7);
        chk("arst_idx", 64'(oLayerIdx), 64'd0);
        chk("arst_busy", 64'(oBusy), 64'd0);
        chk("arst_rom", 64'(oRomAddr), 64'd0);
        repeat (2) @(negedge clk);
        #1 iRst_n = 1;
        launch(4, 5, 6, 3'b000, 1);
        wait_drain();
        chk("restart_done", 64'(oDone), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
